// File: rtl/dmem_responder.sv
// dmem_responder: request/acknowledge data-memory responder with programmable wait
// states, word storage and illegal-access flagging. All state changes on negedge CLK.
// Build option DMEM_BYTE_LANES_EN: stores honour ByteEn lanes; otherwise stores write
// the full word and ByteEn is ignored.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req,
   input  logic        Write,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEn,
   output logic        Ack,
   output logic [31:0] ReadData,
   output logic        Busy,
   output logic        Error
);

   localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  ben_q, ben_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   // access path signals
   logic             acc_go;
   logic             acc_write;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [3:0]       acc_ben;
   logic             acc_legal;
   logic [IDX_W-1:0] mem_idx;
   logic [31:0]      mem_rword;
   logic [31:0]      mem_wword;
   logic [31:0]      lane_mask;
   logic             mem_we;
   logic [3:0]       unused_ben;

   logic [31:0] mem [DEPTH_WORDS];

   // Word-aligned and inside storage; the full 30-bit index is compared so
   // large addresses never alias onto low words.
   function automatic logic legal_addr(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < DEPTH_WORDS);
   endfunction

   // Select the request that drives the access: with no wait states the access
   // happens on the acceptance edge itself, so the live inputs are used there.
   always_comb begin
      acc_go    = 1'b0;
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_ben   = ben_q;
      if (state_q == S_IDLE) begin
         acc_go    = Req && (WAIT_CYCLES == 0);
         acc_write = Write;
         acc_addr  = Address;
         acc_wdata = WriteData;
         acc_ben   = ByteEn;
      end else if (state_q == S_WAIT) begin
         acc_go = (cnt_q == 4'd0);
      end
   end

   // Storage read/merge and load-result update on the edge entering RESP.
   always_comb begin
      acc_legal = legal_addr(acc_addr);
      mem_idx   = acc_addr[IDX_W+1:2];
      mem_rword = mem[mem_idx];
`ifdef DMEM_BYTE_LANES_EN
      lane_mask  = {{8{acc_ben[3]}}, {8{acc_ben[2]}}, {8{acc_ben[1]}}, {8{acc_ben[0]}}};
      unused_ben = '0;
`else
      lane_mask  = '1;
      unused_ben = acc_ben;
`endif
      mem_wword = (mem_rword & ~lane_mask) | (acc_wdata & lane_mask);
      mem_we    = acc_go && acc_write && acc_legal;
      rdata_d   = rdata_q;
      if (acc_go && !acc_write) begin
         rdata_d = acc_legal ? mem_rword : '0;
      end
   end

   // Storage array; deliberately untouched by Reset.
   always_ff @(negedge CLK) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wword;
      end
   end

   // Next-state, request capture and handshake outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ben_d   = ben_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Req) begin
               wr_d    = Write;
               addr_d  = Address;
               wdata_d = WriteData;
               ben_d   = ByteEn;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // Ack and Error are registered on the edge leaving RESP, so both are
            // high for the one cycle after it and clear together on the next edge.
            state_d = S_IDLE;
            ack_d   = 1'b1;
            err_d   = !legal_addr(addr_q);
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) || ack_d;
   end

   // State and output registers with asynchronous reset.
   always_ff @(negedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ben_q   <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ben_q   <= ben_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign Ack      = ack_q;
   assign Busy     = busy_q;
   assign Error    = err_q;
   assign ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        Req, Write, Ack, Busy, Error;
   logic [31:0] Address, WriteData, ReadData;
   logic [3:0]  ByteEn;
   logic        Req0, Write0, Ack0, Busy0, Error0;
   logic [31:0] Address0, WriteData0, ReadData0;
   logic [3:0]  ByteEn0;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;

   logic [32:0] sb0[$];
   logic [32:0] sb1[$];
   int          ack_e0[$];
   int          ack_e1[$];
   logic [31:0] mm[2][256];
   logic [31:0] last_rd[2];

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .CLK(CLK), .Reset(Reset), .Req(Req), .Write(Write), .Address(Address),
      .WriteData(WriteData), .ByteEn(ByteEn), .Ack(Ack), .ReadData(ReadData),
      .Busy(Busy), .Error(Error)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
      .CLK(CLK), .Reset(Reset), .Req(Req0), .Write(Write0), .Address(Address0),
      .WriteData(WriteData0), .ByteEn(ByteEn0), .Ack(Ack0), .ReadData(ReadData0),
      .Busy(Busy0), .Error(Error0)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) edge_n++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: computes the response for a request and queues it.
   task automatic push_exp(input int s, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
      logic        legal;
      logic [7:0]  idx;
      logic [31:0] m_lanes;
      logic [31:0] m;
      legal = (a[1:0] == 2'b00) && (a[31:2] < 30'd256);
      idx   = a[9:2];
      for (int i = 0; i < 4; i++) m_lanes[8*i +: 8] = {8{be[i]}};
`ifdef DMEM_BYTE_LANES_EN
      m = m_lanes;
`else
      m = 32'hFFFF_FFFF | m_lanes;  // ByteEn has no effect in this build
`endif
      if (legal && wr) mm[s][idx] = (mm[s][idx] & ~m) | (d & m);
      else if (!wr)    last_rd[s] = legal ? mm[s][idx] : 32'h0;
      if (s == 0) sb0.push_back({!legal, last_rd[s]});
      else        sb1.push_back({!legal, last_rd[s]});
   endtask

   task automatic drive(input int s, input logic rq, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (s == 0) begin
         Req = rq; Write = wr; Address = a; WriteData = d; ByteEn = be;
      end else begin
         Req0 = rq; Write0 = wr; Address0 = a; WriteData0 = d; ByteEn0 = be;
      end
   endtask

   // One isolated transaction with handshake timing checks; inputs are scrambled
   // right after acceptance.
   task automatic do_req(input int s, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      int lat;
      lat = (s == 0) ? 3 : 1;
      @(posedge CLK);
      drive(s, 1'b1, wr, a, d, be);
      push_exp(s, wr, a, d, be);
      @(negedge CLK); #1;
      check_eq("busy_at_accept", (s == 0) ? Busy : Busy0, 32'd1);
      @(posedge CLK);
      drive(s, 1'b0, ~wr, ~a, ~d, ~be);
      for (int k = 1; k <= lat; k++) begin
         @(negedge CLK); #1;
         check_eq("ack_latency", (s == 0) ? Ack : Ack0, (k == lat) ? 32'd1 : 32'd0);
         check_eq("busy_during", (s == 0) ? Busy : Busy0, 32'd1);
      end
      @(negedge CLK); #1;
      check_eq("ack_drop", (s == 0) ? Ack : Ack0, 32'd0);
      check_eq("busy_drop", (s == 0) ? Busy : Busy0, 32'd0);
   endtask

   // Response monitors: every Ack pops one expectation.
   always begin
      logic [32:0] e;
      @(negedge CLK); #1;
      if (Ack === 1'b1) begin
         ack_e0.push_back(edge_n);
         if (sb0.size() == 0) check_eq("ack_unexpected_w2", {31'b0, Ack}, 32'd0);
         else begin
            e = sb0.pop_front();
            check_eq("rdata_w2", ReadData, e[31:0]);
            check_eq("error_w2", {31'b0, Error}, {31'b0, e[32]});
         end
      end
   end

   always begin
      logic [32:0] e;
      @(negedge CLK); #1;
      if (Ack0 === 1'b1) begin
         ack_e1.push_back(edge_n);
         if (sb1.size() == 0) check_eq("ack_unexpected_w0", {31'b0, Ack0}, 32'd0);
         else begin
            e = sb1.pop_front();
            check_eq("rdata_w0", ReadData0, e[31:0]);
            check_eq("error_w0", {31'b0, Error0}, {31'b0, e[32]});
         end
      end
   end

   initial begin
      int n0;
      int base;
      Reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      repeat (3) @(negedge CLK);
      #1;
      check_eq("rst_ack", Ack, 32'd0);
      check_eq("rst_busy", Busy, 32'd0);
      check_eq("rst_error", Error, 32'd0);
      check_eq("rst_rdata", ReadData, 32'h0);
      check_eq("rst_busy_w0", Busy0, 32'd0);
      @(posedge CLK);
      Reset = 1'b0;

      // basic store then load
      do_req(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);

      // illegal accesses and range boundary
      do_req(0, 1'b1, 32'h0, 32'h5A5A_5A5A, 4'hF);
      do_req(0, 1'b1, 32'h3FC, 32'h0F0F_0F0F, 4'hF);
      do_req(0, 1'b0, 32'h12, 32'h0, 4'hF);
      do_req(0, 1'b0, 32'h400, 32'h0, 4'hF);
      do_req(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF);
      do_req(0, 1'b1, 32'h13, 32'hDEAD_BEEF, 4'hF);
      do_req(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
      do_req(0, 1'b0, 32'h3FC, 32'h0, 4'hF);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);

      // lane-enabled stores
      do_req(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
      do_req(0, 1'b1, 32'h14, 32'h1122_3344, 4'hF);
      do_req(0, 1'b1, 32'h14, 32'h9999_9999, 4'b0000);
      do_req(0, 1'b0, 32'h14, 32'h0, 4'hF);

      // Req held high with a new address each cycle
      for (int k = 0; k < 12; k++) do_req(0, 1'b1, 32'(4*k), 32'hC0DE_0000 + 32'(k), 4'hF);
      n0   = ack_e0.size();
      base = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge CLK);
         if (c == 0) base = edge_n;
         drive(0, 1'b1, 1'b0, 32'(4*c), 32'h0, 4'hF);
         if (c % 4 == 0) push_exp(0, 1'b0, 32'(4*c), 32'h0, 4'hF);
      end
      @(posedge CLK);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (4) @(negedge CLK);
      #1;
      check_eq("burst_ack_count", ack_e0.size() - n0, 32'd3);
      for (int i = 0; i < 3; i++)
         if (n0 + i < ack_e0.size())
            check_eq("burst_ack_edge", ack_e0[n0+i] - base, 32'(4 + 4*i));

      // reset during WAIT of a store
      @(posedge CLK);
      drive(0, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
      @(negedge CLK);
      @(posedge CLK);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1 Reset = 1'b1;
      #1;
      check_eq("midrst_busy", Busy, 32'd0);
      check_eq("midrst_ack", Ack, 32'd0);
      check_eq("midrst_rdata", ReadData, 32'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      n0 = ack_e0.size();
      repeat (2) @(negedge CLK);
      @(posedge CLK);
      Reset = 1'b0;
      repeat (6) @(negedge CLK);
      #1;
      check_eq("midrst_no_ack", ack_e0.size() - n0, 32'd0);
      do_req(0, 1'b0, 32'h20, 32'h0, 4'hF);

      // zero wait states: back-to-back loads
      for (int k = 0; k < 6; k++) do_req(1, 1'b1, 32'(4*k), 32'h0B0B_0000 + 32'(k), 4'hF);
      n0 = ack_e1.size();
      for (int c = 0; c < 6; c++) begin
         @(posedge CLK);
         if (c == 0) base = edge_n;
         drive(1, 1'b1, 1'b0, 32'(4*c), 32'h0, 4'hF);
         if (c % 2 == 0) push_exp(1, 1'b0, 32'(4*c), 32'h0, 4'hF);
      end
      @(posedge CLK);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(negedge CLK);
      #1;
      check_eq("w0_ack_count", ack_e1.size() - n0, 32'd3);
      for (int i = 0; i < 3; i++)
         if (n0 + i < ack_e1.size())
            check_eq("w0_ack_edge", ack_e1[n0+i] - base, 32'(2 + 2*i));

      repeat (4) @(negedge CLK);
      #2;
      check_eq("sb_left_w2", sb0.size(), 32'd0);
      check_eq("sb_left_w0", sb1.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
